// File: rtl/prbs4_checker.sv
// Serial checker for the 4-bit PRBS b[n+4] = b[n] ^ b[n+1] (period 15).
// It seeds a 4-bit history, trains on consecutive matches, then locks and flywheels through bit errors.
module prbs4_checker #(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_ERR = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SEED   = 2'b00,
        TRAIN  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_V   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_ERR);

    state_t     state, state_n;
    logic [3:0] hist, hist_n;
    logic [2:0] seed_cnt, seed_cnt_n;
    logic [3:0] match_cnt, match_cnt_n;
    logic [3:0] win_cnt, win_cnt_n;
    logic [3:0] win_err, win_err_n;
    logic [7:0] err_count_n;
    logic       err_n;

    logic       pred;
    logic       hit;
    logic [3:0] hist_din;
    logic [3:0] hist_pred;
    logic [3:0] match_inc;
    logic [3:0] win_err_base;
    logic [3:0] win_err_inc;

    always_comb begin
        pred         = hist[0] ^ hist[1];
        hit          = (din == pred);
        hist_din     = {din, hist[3:1]};
        hist_pred    = {pred, hist[3:1]};
        match_inc    = match_cnt + 4'd1;
        // An error landing on the wrap bit belongs to the new window.
        win_err_base = (win_cnt == 4'hF) ? 4'd0 : win_err;
        win_err_inc  = win_err_base + 4'd1;

        state_n     = state;
        hist_n      = hist;
        seed_cnt_n  = seed_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_count_n = err_count;
        err_n       = 1'b0;

        if (din_valid) begin
            unique case (state)
                SEED: begin
                    hist_n = hist_din;
                    if (seed_cnt == 3'd3) begin
                        seed_cnt_n = 3'd0;
                        if (hist_din != 4'd0) begin
                            state_n     = TRAIN;
                            match_cnt_n = 4'd0;
                        end
                    end else begin
                        seed_cnt_n = seed_cnt + 3'd1;
                    end
                end
                TRAIN: begin
                    hist_n = hist_din;
                    if (hit) begin
                        match_cnt_n = match_inc;
                        if (match_inc == LOCK_V) begin
                            state_n     = LOCKED;
                            match_cnt_n = 4'd0;
                            win_cnt_n   = 4'd0;
                            win_err_n   = 4'd0;
                        end
                    end else begin
                        state_n     = SEED;
                        match_cnt_n = 4'd0;
                        seed_cnt_n  = 3'd0;
                    end
                end
                LOCKED: begin
                    win_cnt_n = win_cnt + 4'd1;
                    if (hit) begin
                        hist_n    = hist_din;
                        win_err_n = win_err_base;
                    end else begin
                        // Flywheel: keep the locally predicted bit so one bad bit cannot corrupt the history.
                        hist_n      = hist_pred;
                        err_n       = 1'b1;
                        err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                        win_err_n   = win_err_inc;
                        if (win_err_inc == UNLOCK_V) begin
                            state_n    = SEED;
                            seed_cnt_n = 3'd0;
                            win_cnt_n  = 4'd0;
                            win_err_n  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_n    = SEED;
                    seed_cnt_n = 3'd0;
                end
            endcase
        end else if (state != SEED && state != TRAIN && state != LOCKED) begin
            state_n = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEED;
            hist      <= 4'd0;
            seed_cnt  <= 3'd0;
            match_cnt <= 4'd0;
            win_cnt   <= 4'd0;
            win_err   <= 4'd0;
            err_count <= 8'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            seed_cnt  <= seed_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_count <= err_count_n;
            locked    <= (state_n == LOCKED);
            err_pulse <= err_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed-vector bench for prbs4_checker: the driver queues hand-derived expected outputs per cycle,
// and a monitor pops and compares them one step after each rising edge.
module tb_prbs4_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [1:0] state_dbg;

    localparam logic [1:0] S_SEED = 2'b00, S_TRAIN = 2'b01, S_LOCK = 2'b10;

    typedef struct {
        int         tag;
        logic       lk;
        logic       pl;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag   = 0;
    int   pos   = 0;
    int   errs  = 0;
    logic [0:14] pat = 15'b000100110101111;  // b0..b14 of the seed-1000 stream

    prbs4_checker #(.LOCK_CNT(8), .UNLOCK_ERR(3)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({locked, err_pulse, err_count, state_dbg} !== {e.lk, e.pl, e.cnt, e.st}) begin
                n_bad++;
                $display("FAIL t%0d: got lk=%b pl=%b cnt=%0d st=%b, want lk=%b pl=%b cnt=%0d st=%b",
                         e.tag, locked, err_pulse, err_count, state_dbg, e.lk, e.pl, e.cnt, e.st);
            end
        end
    end

    function automatic logic sbit(input int i);
        return pat[i % 15];
    endfunction

    function automatic logic [7:0] sat(input int n);
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    task automatic send(input logic d, input logic v, input logic [1:0] st,
                        input logic lk, input logic pl, input logic [7:0] cnt);
        @(negedge clk);
        reset = 1'b0; din = d; din_valid = v;
        exp_q.push_back('{tag, lk, pl, cnt, st});
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset = 1'b1; din = 1'b1; din_valid = 1'b1;
        exp_q.push_back('{tag, 1'b0, 1'b0, 8'd0, S_SEED});
        pos = 0; errs = 0;
    endtask

    // 4 seed bits, 8 matches; locked appears after the 12th bit. Optional idle gap after each bit.
    task automatic lock_seq(input logic gap);
        for (int k = 0; k < 12; k++) begin
            logic [1:0] st;
            logic b;
            st = (k < 3) ? S_SEED : (k < 11) ? S_TRAIN : S_LOCK;
            b = sbit(pos);
            send(b, 1'b1, st, k == 11, 1'b0, sat(errs));
            if (gap) send(~b, 1'b0, st, k == 11, 1'b0, sat(errs));
            pos++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic lock from the seed-1000 stream, single flywheel error, then window-wrap error accounting
        tag = 1;
        rst_cycle(); rst_cycle();
        lock_seq(1'b0);
        tag = 2;
        errs++; send(~sbit(pos), 1'b1, S_LOCK, 1'b1, 1'b1, sat(errs)); pos++;
        for (int k = 0; k < 15; k++) begin
            send(sbit(pos), 1'b1, S_LOCK, 1'b1, 1'b0, sat(errs)); pos++;
        end
        tag = 3;
        for (int k = 0; k < 18; k++) begin
            logic bad;
            bad = (k == 13 || k == 15 || k == 16 || k == 17);
            if (bad) errs++;
            send(bad ? ~sbit(pos) : sbit(pos), 1'b1, (k == 17) ? S_SEED : S_LOCK,
                 k != 17, bad, sat(errs));
            pos++;
        end

        // Three errors in one window drop lock; the error count survives a relock
        tag = 4;
        rst_cycle();
        lock_seq(1'b0);
        for (int k = 0; k < 5; k++) begin
            logic bad;
            bad = (k % 2 == 0);
            if (bad) errs++;
            send(bad ? ~sbit(pos) : sbit(pos), 1'b1, (k == 4) ? S_SEED : S_LOCK,
                 k != 4, bad, sat(errs));
            pos++;
            if (k == 0) send(1'b0, 1'b0, S_LOCK, 1'b1, 1'b0, sat(errs));
        end
        tag = 5;
        lock_seq(1'b0);

        // All-zero seed is rejected, then a TRAIN mismatch restarts seeding without an error
        tag = 6;
        rst_cycle();
        for (int k = 0; k < 4; k++) send(1'b0, 1'b1, S_SEED, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            send(sbit(pos), 1'b1, (k < 3) ? S_SEED : S_TRAIN, 1'b0, 1'b0, 8'd0); pos++;
        end
        send(~sbit(pos), 1'b1, S_SEED, 1'b0, 1'b0, 8'd0); pos++;
        tag = 7;
        lock_seq(1'b0);

        // din_valid toggling: same 12 accepted bits to lock
        tag = 8;
        rst_cycle();
        lock_seq(1'b1);

        // Error counter saturates at 255; two errors per 16-bit window keep lock
        tag = 9;
        rst_cycle();
        lock_seq(1'b0);
        for (int w = 0; w < 128; w++) begin
            for (int k = 0; k < 16; k++) begin
                logic bad;
                bad = (k == 0 || k == 8);
                if (bad) errs++;
                send(bad ? ~sbit(pos) : sbit(pos), 1'b1, S_LOCK, 1'b1, bad, sat(errs));
                pos++;
            end
        end

        // Reset while locked, with din_valid high, discards history and count
        tag = 10;
        rst_cycle();
        pos = 5;
        lock_seq(1'b0);
        send(sbit(pos), 1'b1, S_LOCK, 1'b1, 1'b0, 8'd0);

        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs4_checker.md
PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 Parameter LOCK_CNT, default 8, SHALL set the number of consecutive correct predicted bits needed to declare lock (range 1..15).
REQ-002 Parameter UNLOCK_ERR, default 3, SHALL set the number of errors within one 16-bit window that forces loss of lock (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 din  input  1  SHALL carry the serial bit stream under test, LSB-first output of the 4-bit ring/LFSR generator.
REQ-006 din_valid  input  1  SHALL qualify din; a bit is accepted only on a clk edge with din_valid=1.
REQ-007 locked  output  1  SHALL be high while the checker is in state LOCKED.
REQ-008 err_pulse  output  1  SHALL give a single-cycle pulse for each mismatched bit accepted in LOCKED.
REQ-009 err_count  output  8  SHALL hold the saturating count of errors flagged since reset.
REQ-010 state_dbg  output  2  SHALL expose the current state encoding: SEED=00, TRAIN=01, LOCKED=10.

Function
REQ-011 The generator recurrence SHALL be b[n+4] = b[n] XOR b[n+1], period 15, with the all-zero pattern illegal.
REQ-012 The checker SHALL keep a 4-bit history hist, updated on each accepted bit as hist <= {new_bit, hist[3:1]}, with hist[0] holding the oldest bit.
REQ-013 The predicted bit SHALL be pred = hist[0] XOR hist[1], evaluated before the shift.
REQ-014 Cycles with din_valid=0 SHALL leave all state, counters and outputs unchanged, except err_pulse, which SHALL be 0.
REQ-015 SEED SHALL shift din into hist and count accepted bits 0..4; on the 4th bit it SHALL go to TRAIN if the resulting hist is non-zero, else stay in SEED with its count cleared.
REQ-016 In TRAIN, on a match (din == pred), the checker SHALL shift din in and increment the match count; when the count reaches LOCK_CNT it SHALL enter LOCKED.
REQ-017 In TRAIN, on a mismatch, the checker SHALL shift din in, clear the match count, go to SEED with the seed count cleared, and flag no error.
REQ-018 In LOCKED, on a match, the checker SHALL shift din in.
REQ-019 In LOCKED, on a mismatch, the checker SHALL shift pred in (flywheel, not din), assert err_pulse the next cycle, and increment err_count, saturating at 255.
REQ-020 LOCKED SHALL keep a 4-bit window counter of accepted bits (wraps 15->0) and an error-in-window counter; both SHALL clear on wrap and on LOCKED entry.
REQ-021 When the error-in-window count reaches UNLOCK_ERR, the checker SHALL go to SEED on that same edge, with locked dropping the following cycle.
REQ-022 If the window wraps on the same edge as an error, that error SHALL count into the new window (new count = 1).
REQ-023 locked, err_pulse and state_dbg SHALL be registered; locked SHALL rise the cycle after the LOCK_CNT-th consecutive match is accepted.
REQ-024 err_count SHALL be cleared only by reset and SHALL persist across lock loss.

Reset
REQ-025 While reset=1 the checker SHALL, at the clock edge, set state=SEED, hist=0000, and clear all counters, with locked=0, err_pulse=0 and err_count=0.
REQ-026 Reset SHALL take priority over din_valid; a reset mid-LOCKED SHALL discard the history, and the first 4 valid bits after release SHALL be seed bits.

Verification
REQ-027 After reset, feed generator output from seed 1000 (b0..b15 = 0001 0011 0101 1110) with din_valid=1 continuously: locked SHALL rise the cycle after bit b11, and err_count SHALL be 0.
REQ-028 When locked, invert one bit: the bench SHALL see one err_pulse, err_count=1, locked still 1, and the next 15 clean bits producing no further errors (flywheel).
REQ-029 When locked, invert 3 bits within 16 accepted bits: locked SHALL fall one cycle after the 3rd error, and err_count SHALL be 3.
REQ-030 Feed 0000 as the first 4 bits, then the valid stream: the checker SHALL stay in SEED until 4 non-zero-history bits are seeded, then lock after LOCK_CNT matches.
REQ-031 Toggle din_valid 1/0 every cycle over the REQ-027 stream: locked SHALL assert after the same 12 accepted bits, and err_pulse SHALL never fire.
REQ-032 Force err_count to 255 with injected errors, then inject one more: err_count SHALL stay at 255, and reset SHALL return it to 0.
